fft_butterfly_5: RTL

//  Radix-2 DIT butterfly consuming fft_stage_5 output: per valid_in takes pair (a,b) + twiddle w,

---
 rtl/fft_butterfly_5.sv | 112 +++++++++++
 1 files changed

// File: rtl/fft_butterfly_5.sv
// Radix-2 DIT butterfly y0 = a + w*b, y1 = a - w*b in a fixed 4-cycle pipeline.
// The twiddle product is rounded, optionally halved and saturated, and the last pair of each frame is flagged.
module fft_butterfly_5 #(
    parameter int Q_IN    = 15,
    parameter int Q_COEFF = 15,
    parameter int Q_OUT   = 15,
    parameter int N       = 256,
    parameter int SCALE   = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             valid_in,
    input  logic [Q_IN:0]    data_in_real_0,
    input  logic [Q_IN:0]    data_in_imag_0,
    input  logic [Q_IN:0]    data_in_real_1,
    input  logic [Q_IN:0]    data_in_imag_1,
    input  logic [Q_COEFF:0] coeff_in_real,
    input  logic [Q_COEFF:0] coeff_in_imag,
    output logic             valid_out,
    output logic [Q_OUT:0]   data_out_real_0,
    output logic [Q_OUT:0]   data_out_imag_0,
    output logic [Q_OUT:0]   data_out_real_1,
    output logic [Q_OUT:0]   data_out_imag_1,
    output logic             sat_flag,
    output logic             frame_done
);
    localparam int PW = Q_IN + Q_COEFF + 2;
    localparam int SW = PW + 1;
    localparam int AW = Q_IN + 3;
    localparam int CW = (N > 2) ? $clog2(N / 2) : 1;

    localparam logic signed [SW-1:0] RND  = SW'(2 ** (Q_COEFF - 1));
    localparam logic signed [AW:0]   ONE  = (AW + 1)'(1);
    localparam logic signed [AW:0]   MAXV = (AW + 1)'(2 ** Q_OUT - 1);
    localparam logic signed [AW:0]   MINV = (AW + 1)'(-(2 ** Q_OUT));
    localparam logic [CW-1:0]        LAST = CW'(N / 2 - 1);

    logic                      v1, v2, v3;
    logic signed [Q_IN:0]      a1_r, a1_i, b1_r, b1_i;
    logic signed [Q_COEFF:0]   w1_r, w1_i;
    logic signed [PW-1:0]      p_rr, p_ii, p_ri, p_ir;
    logic signed [Q_IN:0]      a2_r, a2_i, a3_r, a3_i;
    logic signed [AW-1:0]      bb_r, bb_i;
    logic [CW-1:0]             cnt;
    logic [Q_OUT+1:0]          r0_r, r0_i, r1_r, r1_i;

    // Returns {clip, value}: optional rounded halving, then clamp to the output range.
    function automatic logic [Q_OUT+1:0] scale_sat(input logic signed [AW-1:0] s);
        logic signed [AW:0] t;
        logic               clip;
        t = (AW + 1)'(s);
        if (SCALE != 0) t = (t + ONE) >>> 1;
        clip = 1'b0;
        if (t > MAXV) begin
            t    = MAXV;
            clip = 1'b1;
        end else if (t < MINV) begin
            t    = MINV;
            clip = 1'b1;
        end
        return {clip, t[Q_OUT:0]};
    endfunction

    always_comb begin
        r0_r = scale_sat(AW'(a3_r) + bb_r);
        r0_i = scale_sat(AW'(a3_i) + bb_i);
        r1_r = scale_sat(AW'(a3_r) - bb_r);
        r1_i = scale_sat(AW'(a3_i) - bb_i);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            v1 <= 1'b0; v2 <= 1'b0; v3 <= 1'b0;
            a1_r <= '0; a1_i <= '0; b1_r <= '0; b1_i <= '0; w1_r <= '0; w1_i <= '0;
            p_rr <= '0; p_ii <= '0; p_ri <= '0; p_ir <= '0;
            a2_r <= '0; a2_i <= '0; a3_r <= '0; a3_i <= '0;
            bb_r <= '0; bb_i <= '0;
            cnt <= '0;
            valid_out <= 1'b0; sat_flag <= 1'b0; frame_done <= 1'b0;
            data_out_real_0 <= '0; data_out_imag_0 <= '0;
            data_out_real_1 <= '0; data_out_imag_1 <= '0;
        end else begin
            v1 <= valid_in;
            if (valid_in) begin
                a1_r <= data_in_real_0; a1_i <= data_in_imag_0;
                b1_r <= data_in_real_1; b1_i <= data_in_imag_1;
                w1_r <= coeff_in_real;  w1_i <= coeff_in_imag;
            end
            v2 <= v1;
            if (v1) begin
                p_rr <= b1_r * w1_r; p_ii <= b1_i * w1_i;
                p_ri <= b1_r * w1_i; p_ir <= b1_i * w1_r;
                a2_r <= a1_r; a2_i <= a1_i;
            end
            v3 <= v2;
            if (v2) begin
                // Round half up, then drop the coefficient fraction bits.
                bb_r <= AW'((SW'(p_rr) - SW'(p_ii) + RND) >>> Q_COEFF);
                bb_i <= AW'((SW'(p_ri) + SW'(p_ir) + RND) >>> Q_COEFF);
                a3_r <= a2_r; a3_i <= a2_i;
            end
            valid_out  <= v3;
            sat_flag   <= v3 && (r0_r[Q_OUT+1] || r0_i[Q_OUT+1] || r1_r[Q_OUT+1] || r1_i[Q_OUT+1]);
            frame_done <= v3 && (cnt == LAST);
            if (v3) begin
                data_out_real_0 <= r0_r[Q_OUT:0]; data_out_imag_0 <= r0_i[Q_OUT:0];
                data_out_real_1 <= r1_r[Q_OUT:0]; data_out_imag_1 <= r1_i[Q_OUT:0];
                cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
            end
        end
    end
endmodule
